// File: rtl/hazard_scoreboard_pkg.sv
// Shared core package for the hazard scoreboard.
// Provides the register-address type, the x0 constant, scoreboard widths
// and a small helper used by the scoreboard datapath.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned PERF_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);

  // True when the register address names a real (writable) register.
  function automatic logic is_real_reg(input reg_addr_t addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order pipeline scoreboard for long-latency writes.
// Tracks pending destination registers, raises a decode stall on RAW / WAW /
// load-use / capacity hazards, and flags completions with no matching entry.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   id_rs1_addr, id_rs2_addr      decode sources
//   id_rd_addr, id_reg_write      decode destination and write enable
//   id_long_lat, id_valid         decode op is long-latency / decode valid
//   ex_mem_read, ex_rd_addr       load in EX and its destination
//   cmp_valid, cmp_rd_addr        long-latency writeback completion
//   flush                         squash the decode instruction
//   stall                         combinational hold of decode and fetch
//   pending_mask, outstanding     registered scoreboard state
//   err_sticky                    sticky bad-completion flag
//   stall_cycles                  stall performance counter
//
// Optional feature macro: HAZARD_SCOREBOARD_PERF_EN enables the saturating
// stall_cycles counter; without it stall_cycles is tied to zero.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_reg_write,
  input  logic        id_long_lat,
  input  logic        id_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd_addr,
  input  logic        cmp_valid,
  input  logic [4:0]  cmp_rd_addr,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] pending_mask,
  output logic [3:0]  outstanding,
  output logic        err_sticky,
  output logic [31:0] stall_cycles
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                err_q, err_d;

  logic rs1_hit, rs2_hit, waw_hit, load_use, full;
  logic issue_ok, cmp_ok, cmp_err;

  // Hazard detection from registered state only (no completion bypass).
  always_comb begin
    rs1_hit  = is_real_reg(id_rs1_addr) && pending_q[id_rs1_addr];
    rs2_hit  = is_real_reg(id_rs2_addr) && pending_q[id_rs2_addr];
    waw_hit  = id_reg_write && is_real_reg(id_rd_addr) && pending_q[id_rd_addr];
    load_use = ex_mem_read && is_real_reg(ex_rd_addr) &&
               ((is_real_reg(id_rs1_addr) && (ex_rd_addr == id_rs1_addr)) ||
                (is_real_reg(id_rs2_addr) && (ex_rd_addr == id_rs2_addr)));
    full     = outstanding_q == CNT_W'(MAX_OUTSTANDING);
    stall    = id_valid && !flush &&
               (rs1_hit || rs2_hit || waw_hit || load_use || (id_long_lat && full));
  end

  // Next-state: issue sets, completion clears; both may land in one cycle.
  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;

    issue_ok = id_valid && id_long_lat && id_reg_write && is_real_reg(id_rd_addr) &&
               !stall && !flush;
    cmp_ok   = cmp_valid && is_real_reg(cmp_rd_addr) && pending_q[cmp_rd_addr];
    cmp_err  = cmp_valid && !cmp_ok;

    if (issue_ok) pending_d[id_rd_addr]  = 1'b1;
    if (cmp_ok)   pending_d[cmp_rd_addr] = 1'b0;
    pending_d[0] = 1'b0;

    outstanding_d = outstanding_q + CNT_W'(issue_ok) - CNT_W'(cmp_ok);
    if (cmp_err) err_d = 1'b1;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign pending_mask = pending_q;
  assign outstanding  = outstanding_q;
  assign err_sticky   = err_q;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q;

  // Saturating count of stalled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (MAX_OUTSTANDING = 4).
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_reg_write, id_long_lat, id_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        cmp_valid;
  logic [4:0]  cmp_rd_addr;
  logic        flush;
  logic        stall;
  logic [31:0] pending_mask;
  logic [3:0]  outstanding;
  logic        err_sticky;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.MAX_OUTSTANDING(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rd_addr   (id_rd_addr),
    .id_reg_write (id_reg_write),
    .id_long_lat  (id_long_lat),
    .id_valid     (id_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_rd_addr   (ex_rd_addr),
    .cmp_valid    (cmp_valid),
    .cmp_rd_addr  (cmp_rd_addr),
    .flush        (flush),
    .stall        (stall),
    .pending_mask (pending_mask),
    .outstanding  (outstanding),
    .err_sticky   (err_sticky),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v, rw, ll, exm, cv, fl;
    logic [4:0] rs1, rs2, rd, exr, cr;
    logic       s;
    logic [31:0] m;
    logic [3:0] o;
    logic       e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic rw, input logic ll,
                              input int rs1, input int rs2, input int rd,
                              input logic exm, input int exr,
                              input logic cv, input int cr, input logic fl,
                              input logic s, input int m, input int o, input logic e);
    vec_t t;
    t.v = v; t.rw = rw; t.ll = ll;
    t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
    t.exm = exm; t.exr = 5'(exr);
    t.cv = cv; t.cr = 5'(cr); t.fl = fl;
    t.s = s; t.m = 32'(m); t.o = 4'(o); t.e = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_reg_write = t.rw; id_long_lat = t.ll;
    id_rs1_addr = t.rs1; id_rs2_addr = t.rs2; id_rd_addr = t.rd;
    ex_mem_read = t.exm; ex_rd_addr = t.exr;
    cmp_valid = t.cv; cmp_rd_addr = t.cr; flush = t.fl;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0,0, 0,0, 0,0, 0, 0,0,0,0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    // v rw ll rs1 rs2 rd exm exr cv cr fl | stall mask out err
    vecs.push_back(mk(0,0,0, 0,0,0,  0,0, 0,0, 0, 0,'h000,0,0));
    vecs.push_back(mk(1,1,1, 1,2,5,  0,0, 0,0, 0, 0,'h020,1,0)); // issue load x5
    vecs.push_back(mk(1,1,0, 5,0,10, 0,0, 0,0, 0, 1,'h020,1,0)); // RAW on x5
    vecs.push_back(mk(1,1,0, 5,0,10, 0,0, 1,5, 0, 1,'h000,0,0)); // completion not bypassed
    vecs.push_back(mk(1,1,0, 5,0,10, 0,0, 0,0, 0, 0,'h000,0,0));
    vecs.push_back(mk(1,1,0, 1,7,10, 1,7, 0,0, 0, 1,'h000,0,0)); // load-use rs2=x7
    vecs.push_back(mk(1,1,0, 1,7,10, 0,0, 0,0, 0, 0,'h000,0,0)); // only one cycle
    vecs.push_back(mk(1,1,0, 0,0,10, 1,0, 0,0, 0, 0,'h000,0,0)); // x0 load-use ignored
    vecs.push_back(mk(1,0,0, 0,0,0,  1,7, 0,0, 0, 0,'h000,0,0));
    vecs.push_back(mk(1,1,1, 0,0,1,  0,0, 0,0, 0, 0,'h002,1,0)); // x1..x4
    vecs.push_back(mk(1,1,1, 0,0,2,  0,0, 0,0, 0, 0,'h006,2,0));
    vecs.push_back(mk(1,1,1, 0,0,3,  0,0, 0,0, 0, 0,'h00E,3,0));
    vecs.push_back(mk(1,1,1, 0,0,4,  0,0, 0,0, 0, 0,'h01E,4,0));
    vecs.push_back(mk(1,1,1, 0,0,6,  0,0, 0,0, 0, 1,'h01E,4,0)); // full
    vecs.push_back(mk(1,1,1, 0,0,6,  0,0, 1,2, 0, 1,'h01A,3,0)); // complete x2, still stalled
    vecs.push_back(mk(1,1,1, 0,0,6,  0,0, 0,0, 0, 0,'h05A,4,0)); // x6 accepted
    vecs.push_back(mk(1,1,0, 0,0,3,  0,0, 0,0, 0, 1,'h05A,4,0)); // WAW x3
    vecs.push_back(mk(1,0,0, 0,0,3,  0,0, 0,0, 0, 0,'h05A,4,0)); // no write, no WAW
    vecs.push_back(mk(0,0,0, 0,0,0,  0,0, 1,1, 0, 0,'h058,3,0));
    vecs.push_back(mk(1,1,1, 0,0,8,  0,0, 1,3, 0, 0,'h150,3,0)); // issue+complete same edge
    vecs.push_back(mk(0,0,0, 0,0,0,  0,0, 1,9, 0, 0,'h150,3,1)); // bad completion x9
    vecs.push_back(mk(0,0,0, 0,0,0,  0,0, 1,0, 0, 0,'h150,3,1)); // completion to x0
    vecs.push_back(mk(1,1,1, 4,0,3,  0,0, 0,0, 1, 0,'h150,3,1)); // flushed issue
    vecs.push_back(mk(1,1,1, 0,0,0,  0,0, 0,0, 0, 0,'h150,3,1)); // rd=0 long op
    vecs.push_back(mk(0,0,0, 4,0,0,  0,0, 0,0, 0, 0,'h150,3,1));
    vecs.push_back(mk(1,1,0, 4,0,9,  0,0, 0,0, 0, 1,'h150,3,1)); // x4 still pending
    vecs.push_back(mk(0,0,0, 0,0,0,  0,0, 1,4, 0, 0,'h140,2,1)); // retained bit clears

    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_mask", pending_mask, 32'h0);
    chk("rst_out", 32'(outstanding), 32'h0);
    chk("rst_err", 32'(err_sticky), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_perf", stall_cycles, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].s));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_mask", i), pending_mask, vecs[i].m);
      chk($sformatf("v%0d_out", i), 32'(outstanding), 32'(vecs[i].o));
      chk($sformatf("v%0d_err", i), 32'(err_sticky), 32'(vecs[i].e));
    end

    // Asynchronous reset mid-flight, away from any clock edge.
    @(negedge clk);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mask", pending_mask, 32'h0);
    chk("midrst_out", 32'(outstanding), 32'h0);
    chk("midrst_err", 32'(err_sticky), 32'h0);
    // During reset stall still follows the combinational load-use term.
    drive(mk(1,1,0, 12,0,10, 1,12, 0,0, 0, 0,0,0,0));
    #1;
    chk("rst_loaduse_stall", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    chk("rst_perf_hold", stall_cycles, 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Completion of an op issued before reset is discarded and flagged.
    @(negedge clk);
    drive(mk(0,0,0, 0,0,0, 0,0, 1,6, 0, 0,0,0,0));
    @(posedge clk);
    #1;
    chk("stale_cmp_err", 32'(err_sticky), 32'h1);
    chk("stale_cmp_mask", pending_mask, 32'h0);
    chk("stale_cmp_out", 32'(outstanding), 32'h0);

    // Hold a load-use stall for ten edges.
    @(negedge clk);
    drive(mk(1,1,0, 12,0,10, 1,12, 0,0, 0, 0,0,0,0));
    for (int c = 0; c < 10; c++) @(posedge clk);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    chk("perf_count", stall_cycles, 32'd10);
`else
    chk("perf_count", stall_cycles, 32'd0);
`endif
    chk("perf_err_persist", 32'(err_sticky), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of long-latency writes in flight (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports id_rs1_addr and id_rs2_addr, input, 5 bits each: source registers of the instruction in decode.
REQ-005 SHALL have port id_rd_addr, input, 5 bits: destination register of the decode instruction.
REQ-006 SHALL have port id_reg_write, input, 1 bit: decode instruction writes rd.
REQ-007 SHALL have port id_long_lat, input, 1 bit: decode instruction is a long-latency op (load, mul, div).
REQ-008 SHALL have port id_valid, input, 1 bit: decode holds a valid instruction.
REQ-009 SHALL have ports ex_mem_read (input, 1 bit) and ex_rd_addr (input, 5 bits): a load occupies EX and names its destination.
REQ-010 SHALL have ports cmp_valid (input, 1 bit) and cmp_rd_addr (input, 5 bits): a long-latency op completes writeback this cycle.
REQ-011 SHALL have port flush, input, 1 bit: the decode instruction is squashed this cycle.
REQ-012 SHALL have port stall, output, 1 bit: hold decode and fetch this cycle.
REQ-013 SHALL have port pending_mask, output, 32 bits: registered per-register pending-write bits.
REQ-014 SHALL have port outstanding, output, 4 bits: registered in-flight count.
REQ-015 SHALL have port err_sticky, output, 1 bit: sticky protocol-error flag.
REQ-016 SHALL have port stall_cycles, output, 32 bits: performance counter (see Configuration).

Function
REQ-017 SHALL assert stall combinationally when id_valid=1, flush=0, and any of the following holds: a nonzero rs1 or rs2 has its pending bit set; id_reg_write=1 with nonzero rd and that rd pending (WAW); ex_mem_read=1 with nonzero ex_rd_addr equal to a nonzero rs1 or rs2 (load-use, 1 cycle); id_long_lat=1 and outstanding equals MAX_OUTSTANDING.
REQ-018 SHALL never flag register x0 as a hazard; pending bit 0 SHALL always read 0.
REQ-019 SHALL accept an issue when id_valid=1, id_long_lat=1, id_reg_write=1, rd≠0, stall=0 and flush=0; on the next edge it SHALL set pending_mask[rd] and increment outstanding.
REQ-020 SHALL clear pending_mask[cmp_rd_addr] and decrement outstanding on the edge after cmp_valid=1 with a currently set bit.
REQ-021 SHALL NOT bypass a same-cycle completion: stall is computed from the registered mask only.
REQ-022 SHALL, on a simultaneous accepted issue and valid completion (necessarily different registers), apply both, leaving outstanding unchanged.
REQ-023 SHALL, on cmp_valid to a register whose bit is clear or to x0, leave all state unchanged and set err_sticky.
REQ-024 SHALL treat flush as squashing only the decode instruction: in-flight pending bits are retained and their completions still clear them.
REQ-025 SHALL make outstanding equal to the population count of pending_mask at all times.

Reset
REQ-026 SHALL, while rst_n=0, clear pending_mask, outstanding, err_sticky and stall_cycles to 0 asynchronously; stall then reflects only the combinational load-use and input terms.
REQ-027 SHALL discard completions of operations issued before a mid-operation reset and flag them per REQ-023.

Configuration
REQ-028 SHALL, with HAZARD_SCOREBOARD_PERF_EN defined, increment stall_cycles by 1 on each edge where stall=1, saturating at 0xFFFFFFFF.
REQ-029 SHALL, without HAZARD_SCOREBOARD_PERF_EN, tie stall_cycles to 0 and synthesize no counter.

Structure
REQ-030 SHALL take the register-address typedef (5 bits) and the constant REG_ZERO from the shared core package.
REQ-031 SHALL be a single module with no sub-modules.

Verification
REQ-032 Issue a load to x5, then decode reads x5 on the next cycle -> stall=1 until the cycle after cmp_valid for x5; pending_mask goes 0x20 -> 0.
REQ-033 EX load to x7 while decode reads rs2=x7 with no scoreboard entry -> stall=1 for exactly 1 cycle.
REQ-034 MAX_OUTSTANDING=4: issue long ops to x1..x4, then a fifth to x6 -> stall=1, outstanding=4; complete x2 -> next cycle the x6 issue is accepted.
REQ-035 cmp_valid for x9 while it is not pending -> err_sticky=1; mask and count are unchanged; the flag persists until reset.
REQ-036 Issue to x3 with flush=1 -> no bit is set; rd=0 long op -> no bit is set; rst_n low mid-flight -> all outputs are 0 immediately.
REQ-037 With the PERF macro defined, hold stall for 10 cycles -> stall_cycles=10; without the macro -> stall_cycles=0.
